data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096, number of 32-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 1, legal range 1..8, cycles from request acceptance to response.
REQ-003 SHALL have clk  input  1  single clock; every state change occurs on its rising edge.
REQ-004 SHALL have clr  input  1  reset; synchronous and active-high.
REQ-005 SHALL have req_valid  input  1  request present.
REQ-006 SHALL have req_ready  output  1  block can accept a request this cycle.
REQ-007 SHALL have req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have req_size  input  2  00 word, 01 byte, 10 halfword, 11 reserved.
REQ-009 SHALL have req_sext  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-010 SHALL have req_addr  input  32  byte address.
REQ-011 SHALL have req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 SHALL have req_pc  input  32  PC of the issuing instruction, used for the store log.
REQ-013 SHALL have resp_valid  output  1  one-cycle response strobe.
REQ-014 SHALL have resp_rdata  output  32  extended load data; 0 for stores and exceptions.
REQ-015 SHALL have resp_exc  output  1  address exception, qualified by resp_valid.
REQ-016 SHALL have busy  output  1  request outstanding (inverse of req_ready).

Function
REQ-017 SHALL implement FSM IDLE -> WAIT -> IDLE; req_ready = 1 only in IDLE.
REQ-018 SHALL accept a request in cycle T when req_valid && req_ready; it SHALL capture all req_* fields at that edge.
REQ-019 SHALL load a latency counter with LATENCY-1 on acceptance and decrement it each cycle in WAIT.
REQ-020 SHALL assert resp_valid for exactly one cycle, in cycle T+LATENCY, then return to IDLE.
REQ-021 SHALL accept the next request no earlier than cycle T+LATENCY, the same cycle as resp_valid (back-to-back throughput one request per LATENCY cycles).
REQ-022 SHALL use word index addr[31:2]; byte lane addr[1:0]; half lane addr[1].
REQ-023 SHALL flag an exception when: size 11; half with addr[0]=1; word with addr[1:0]!=0; or addr[31:2] >= DEPTH_WORDS.
REQ-024 SHALL, for an excepting request, neither read nor modify memory, respond at T+LATENCY with resp_exc=1 and resp_rdata=0.
REQ-025 SHALL perform a store read-modify-write on the acceptance edge, changing only the addressed byte or half lanes.
REQ-026 SHALL print "@<pc>: *<word-aligned addr> <= <full new word>" (hex, 8 digits) for each committed store at the commit edge; no line for excepting stores.
REQ-027 SHALL sample load data at T+LATENCY from memory contents at that cycle.
REQ-028 SHALL extract the lane and extend it per req_sext; word loads ignore req_sext.
REQ-029 SHALL ignore req_valid while busy; inputs changing during WAIT SHALL NOT affect the outstanding response.

Reset
REQ-030 SHALL, when clr=1 at an edge, zero every memory word, set FSM to IDLE, counter to 0, resp_valid=0, resp_exc=0, resp_rdata=0.
REQ-031 SHALL give clr priority over a simultaneous store: the store is dropped and not logged.
REQ-032 SHALL, when clr hits during WAIT, abort the outstanding request with no response.
REQ-033 SHALL power up with all memory words zero and outputs at reset values.

Verification
REQ-034 LATENCY=3: store word 0x12345678 to 0x10 at T -> resp_valid at T+3 only, resp_exc=0; log "@<pc>: *00000010 <= 12345678".
REQ-035 After REQ-034: store byte 0xAB to 0x11 -> word becomes 0x1234AB78; load byte 0x11 sext=1 -> 0xFFFFFFAB; sext=0 -> 0x000000AB.
REQ-036 Load half from 0x12, sext=1, word 0x8001FFFF -> 0xFFFF8001; load half 0x13 -> resp_exc=1, rdata 0, memory unchanged.
REQ-037 LATENCY=2: req_valid held high with two requests -> second accepted in the cycle of first resp_valid; req_ready low in between.
REQ-038 Store accepted with clr=1 in the same cycle -> memory stays 0, no log; clr during WAIT -> no resp_valid, req_ready=1 next cycle.
REQ-039 Address with addr[31:2]=DEPTH_WORDS -> resp_exc=1 for both load and store, no memory change.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Word-organised data memory with a fixed-latency request/response handshake,
// byte/half/word lanes, load extension, alignment/range exceptions and a store log.
//
// state  | meaning
// S_IDLE | ready for a request; a response, if any, is presented this cycle
// S_WAIT | request outstanding; latency counter running down
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sext,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_exc,
  output logic        busy
);

  localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [2:0] CNT_LOAD = 3'(LATENCY - 1);
  localparam logic [1:0] SZ_WORD  = 2'b00;
  localparam logic [1:0] SZ_BYTE  = 2'b01;
  localparam logic [1:0] SZ_HALF  = 2'b10;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  function automatic logic addr_exc(input logic [1:0] size, input logic [31:0] addr);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_WORD: bad = (addr[1:0] != 2'b00);
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr[0];
      default: bad = 1'b1;
    endcase
    if ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS)) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] w;
    w = old_word;
    case (size)
      SZ_WORD: w = wdata;
      SZ_BYTE: w[{lane, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (lane[1]) w[31:16] = wdata[15:0];
        else         w[15:0]  = wdata[15:0];
      end
      default: w = old_word;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic        sext,
                                               input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{sext & b[7]}}, b};
      SZ_HALF: r = {{16{sext & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  state_t      state;
  logic [2:0]  cnt;
  logic [31:0] mem [DEPTH_WORDS];

  logic          cap_we;
  logic          cap_sext;
  logic          cap_exc;
  logic [1:0]    cap_size;
  logic [1:0]    cap_lane;
  logic [AW-1:0] cap_idx;

  logic          accept;
  logic          live_exc;
  logic [AW-1:0] live_idx;
  logic [31:0]   store_word;
  logic          fin;
  logic          f_we;
  logic          f_sext;
  logic          f_exc;
  logic [1:0]    f_size;
  logic [1:0]    f_lane;
  logic [AW-1:0] f_idx;
  logic [31:0]   rd_word;

  assign req_ready  = (state == S_IDLE);
  assign busy       = (state == S_WAIT);
  assign accept     = req_valid && req_ready;
  assign live_idx   = req_addr[AW+1:2];
  assign live_exc   = addr_exc(req_size, req_addr);
  assign store_word = merge_store(mem[live_idx], req_wdata, req_size, req_addr[1:0]);

  // With LATENCY=1 the response is produced on the acceptance edge itself,
  // so the response fields come straight from the live request.
  assign fin = ((state == S_WAIT) && (cnt == 3'd1)) || (accept && (LATENCY == 1));

  always_comb begin
    f_we   = cap_we;
    f_sext = cap_sext;
    f_exc  = cap_exc;
    f_size = cap_size;
    f_lane = cap_lane;
    f_idx  = cap_idx;
    if (state == S_IDLE) begin
      f_we   = req_we;
      f_sext = req_sext;
      f_exc  = live_exc;
      f_size = req_size;
      f_lane = req_addr[1:0];
      f_idx  = live_idx;
    end
  end

  assign rd_word = mem[f_idx];

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= S_IDLE;
      cnt        <= 3'd0;
      resp_valid <= 1'b0;
      resp_exc   <= 1'b0;
      resp_rdata <= 32'd0;
      cap_we     <= 1'b0;
      cap_sext   <= 1'b0;
      cap_exc    <= 1'b0;
      cap_size   <= 2'b00;
      cap_lane   <= 2'b00;
      cap_idx    <= '0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
    end else begin
      resp_valid <= 1'b0;
      resp_exc   <= 1'b0;
      resp_rdata <= 32'd0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cap_we   <= req_we;
            cap_sext <= req_sext;
            cap_exc  <= live_exc;
            cap_size <= req_size;
            cap_lane <= req_addr[1:0];
            cap_idx  <= live_idx;
            if (req_we && !live_exc) mem[live_idx] <= store_word;
            if (LATENCY > 1) begin
              state <= S_WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (fin) begin
        resp_valid <= 1'b1;
        resp_exc   <= f_exc;
        resp_rdata <= (f_we || f_exc) ? 32'd0 : extract_load(rd_word, f_size, f_sext, f_lane);
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!clr && accept && req_we && !live_exc)
      $display("@%08h: *%08h <= %08h", req_pc, {req_addr[31:2], 2'b00}, store_word);
  end
`endif

endmodule
